// File: rtl/fwrisc_mem_pkg.sv
// Shared types and constants for the fwrisc boot/program RAM responder.
`timescale 1ns/1ps
package fwrisc_mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   typedef enum logic {PORT_I, PORT_D} port_e;

   // Selects what the granted port sees on its data output during RESP.
   typedef enum logic [1:0] {RK_ZERO, RK_MEM, RK_BEEF} resp_kind_e;

   localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

   typedef struct packed {
      port_e       port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstb;
      logic        write;
      logic [3:0]  amo;
   } req_t;

   function automatic resp_kind_e resp_kind(input logic hit, input logic write,
                                            input logic [3:0] amo);
      if (!hit)               return RK_BEEF;
      else if (amo != 4'h0)   return RK_MEM;
      else if (write)         return RK_ZERO;
      else                    return RK_MEM;
   endfunction

endpackage

// File: rtl/fwrisc_mem_sram.sv
// Single-port 32-bit SRAM with byte write enables and registered read.
`timescale 1ns/1ps
module fwrisc_mem_sram #(
   parameter int    ADDR_BITS = 12,
   parameter string INIT_FILE = ""
) (
   input  logic                 clock,
   input  logic                 en,
   input  logic [3:0]           we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [0:2**ADDR_BITS-1];
   logic [31:0] rdata_q;

   // NOTE: the array and its read register carry no reset; clearing a RAM is not
   // something the hardware can do in one edge, and contents must survive reset.
   always_ff @(posedge clock) begin
      if (en) begin
         rdata_q <= mem[addr];
      end
      for (int k = 0; k < 4; k++) begin
         if (we[k]) begin
            mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fwrisc_mem_responder.sv
// Target for the fwrisc i/d buses: round-robin arbiter, per-port wait states,
// window/AMO error detection and response muxing in front of one SRAM.
`timescale 1ns/1ps
module fwrisc_mem_responder
   import fwrisc_mem_pkg::*;
#(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] BASE      = 32'h8000_0000,
   parameter int          WAIT_I    = 0,
   parameter int          WAIT_D    = 0,
   parameter string       INIT_FILE = ""
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] iaddr,
   input  logic        ivalid,
   output logic [31:0] idata,
   output logic        iready,
   input  logic        dvalid,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwstb,
   input  logic        dwrite,
   input  logic [3:0]  damo,
   output logic [31:0] drdata,
   output logic        dready,
   output logic        err
);

   localparam int         HI       = ADDR_BITS + 2;
   localparam logic [3:0] WAIT_I_C = 4'(WAIT_I);
   localparam logic [3:0] WAIT_D_C = 4'(WAIT_D);

   state_e       state_q, state_d;
   port_e        last_grant_q, last_grant_d;
   req_t         req_q, req_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         iready_q, iready_d;
   logic         dready_q, dready_d;
   logic         err_q, err_d;
   resp_kind_e   kind_q, kind_d;
   logic [31:0]  idata_hold_q, idata_hold_d;
   logic [31:0]  drdata_hold_q, drdata_hold_d;

   req_t         req_in, cur;
   port_e        gnt_port;
   logic         gnt_valid;
   logic [3:0]   wait_cfg;
   logic         fire, hit;
   logic         sram_en;
   logic [3:0]   sram_we;
   logic [31:0]  sram_rdata, resp_data;
   logic         unused_addr_lsbs;

   always_comb begin
      gnt_valid = ivalid | dvalid;
      if (ivalid && dvalid) gnt_port = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
      else                  gnt_port = dvalid ? PORT_D : PORT_I;

      req_in.port  = gnt_port;
      req_in.addr  = (gnt_port == PORT_D) ? daddr : iaddr;
      req_in.wdata = dwdata;
      req_in.wstb  = dwstb;
      req_in.write = (gnt_port == PORT_D) && dwrite;
      req_in.amo   = (gnt_port == PORT_D) ? damo : 4'h0;
      wait_cfg     = (gnt_port == PORT_D) ? WAIT_D_C : WAIT_I_C;
   end

   // In IDLE the access can fire on the sampling edge, so it is driven straight from the bus.
   always_comb begin
      cur     = (state_q == IDLE) ? req_in : req_q;
      hit     = (cur.addr[31:HI] == BASE[31:HI]);
      fire    = ((state_q == IDLE) && gnt_valid && (wait_cfg == 4'h0)) ||
                ((state_q == WAIT) && (cnt_q == 4'h0));
      sram_en = fire && hit;
      sram_we = (fire && hit && cur.write && (cur.amo == 4'h0) && !reset) ? cur.wstb : 4'h0;
   end

   assign unused_addr_lsbs = ^cur.addr[1:0];

   fwrisc_mem_sram #(
      .ADDR_BITS (ADDR_BITS),
      .INIT_FILE (INIT_FILE)
   ) u_sram (
      .clock (clock),
      .en    (sram_en),
      .we    (sram_we),
      .addr  (cur.addr[HI-1:2]),
      .wdata (cur.wdata),
      .rdata (sram_rdata)
   );

   always_comb begin
      case (kind_q)
         RK_MEM:  resp_data = sram_rdata;
         RK_BEEF: resp_data = DEADBEEF;
         default: resp_data = 32'h0;
      endcase
   end

   always_comb begin
      // NOTE: every signal gets its default first so no path through the case infers a latch.
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      req_d         = req_q;
      cnt_d         = cnt_q;
      iready_d      = 1'b0;
      dready_d      = 1'b0;
      err_d         = 1'b0;
      kind_d        = kind_q;
      idata_hold_d  = idata_hold_q;
      drdata_hold_d = drdata_hold_q;

      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               req_d = req_in;
               if (!fire) begin
                  state_d = WAIT;
                  // The first WAIT cycle already counts as one of the wait states.
                  cnt_d   = wait_cfg - 4'd1;
               end
            end
         end
         WAIT: begin
            if (!fire) cnt_d = cnt_q - 4'd1;
         end
         RESP: begin
            state_d      = IDLE;
            last_grant_d = req_q.port;
            if (req_q.port == PORT_I) idata_hold_d  = resp_data;
            else                      drdata_hold_d = resp_data;
         end
         default: state_d = IDLE;
      endcase

      if (fire) begin
         state_d  = RESP;
         iready_d = (cur.port == PORT_I);
         dready_d = (cur.port == PORT_D);
         err_d    = !hit || (cur.amo != 4'h0);
         kind_d   = resp_kind(hit, cur.write, cur.amo);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= PORT_I;
         req_q         <= '0;
         cnt_q         <= 4'h0;
         iready_q      <= 1'b0;
         dready_q      <= 1'b0;
         err_q         <= 1'b0;
         kind_q        <= RK_ZERO;
         idata_hold_q  <= 32'h0;
         drdata_hold_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         req_q         <= req_d;
         cnt_q         <= cnt_d;
         iready_q      <= iready_d;
         dready_q      <= dready_d;
         err_q         <= err_d;
         kind_q        <= kind_d;
         idata_hold_q  <= idata_hold_d;
         drdata_hold_q <= drdata_hold_d;
      end
   end

   assign iready = iready_q;
   assign dready = dready_q;
   assign err    = err_q;
   assign idata  = iready_q ? resp_data : idata_hold_q;
   assign drdata = dready_q ? resp_data : drdata_hold_q;

endmodule
